// File: rtl/pair_pattern_tx_if.sv
// Handshake and serial-output bundle for pair_pattern_tx.
// The master side loads patterns; the slave side is the serializer.
interface pair_pattern_tx_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic [4:0]       len;
  logic             ready;
  logic             bit_valid;
  logic             bit_out;
  logic             expect_out;
  logic [3:0]       pair_count;
  logic             done;

  modport master (
    output load, data, len,
    input  ready, bit_valid, bit_out, expect_out, pair_count, done
  );

  modport slave (
    input  load, data, len,
    output ready, bit_valid, bit_out, expect_out, pair_count, done
  );
endinterface

// File: rtl/pair_pattern_tx.sv
// Serializes a loaded pattern LSB first and predicts a pair detector's
// registered output, counting non-overlapping equal-bit pairs.
module pair_pattern_tx #(
  parameter int WIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  pair_pattern_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {START, ONE, ZERO} model_t;

  state_t           state;
  model_t           model;
  model_t           next_model;
  logic [WIDTH-1:0] shreg;
  logic [4:0]       count;
  logic [4:0]       load_count;
  logic             expect_q;
  logic [3:0]       pairs;
  logic             cur_bit;
  logic             match;

  assign cur_bit = shreg[0];

  // A length of zero or anything above 16 sends a full 16-bit pattern.
  assign load_count = ((bus.len == 5'd0) || (bus.len > 5'd16)) ? 5'd16 : bus.len;

  // Pair detector model: a match consumes both bits of the pair.
  always_comb begin
    match      = 1'b0;
    next_model = START;
    case (model)
      START: next_model = cur_bit ? ONE : ZERO;
      ONE: begin
        if (cur_bit) begin
          next_model = START;
          match      = 1'b1;
        end else begin
          next_model = ZERO;
        end
      end
      ZERO: begin
        if (!cur_bit) begin
          next_model = START;
          match      = 1'b1;
        end else begin
          next_model = ONE;
        end
      end
      default: next_model = START;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      model    <= START;
      shreg    <= '0;
      count    <= 5'd0;
      expect_q <= 1'b0;
      pairs    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          expect_q <= 1'b0;
          if (bus.load) begin
            shreg <= bus.data;
            count <= load_count;
            pairs <= 4'd0;
            model <= START;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg    <= shreg >> 1;
          count    <= count - 5'd1;
          model    <= next_model;
          expect_q <= match;
          if (match && (pairs != 4'd15)) begin
            pairs <= pairs + 4'd1;
          end
          if (count == 5'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          expect_q <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          expect_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = (state == IDLE);
  assign bus.bit_valid  = (state == SHIFT);
  assign bus.bit_out    = (state == SHIFT) && cur_bit;
  assign bus.done       = (state == DONE);
  assign bus.expect_out = expect_q;
  assign bus.pair_count = pairs;

endmodule

// File: tb/tb_pair_pattern_tx.sv
// Scoreboard bench for pair_pattern_tx: expected bits and predictions are
// queued at load time and compared as the serializer emits them.
module tb_pair_pattern_tx;

  typedef struct packed {
    logic b;
    logic ex;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   assertions = 0;
  int   failures = 0;
  item_t sb[$];

  pair_pattern_tx_if #(.WIDTH(16)) bus ();

  pair_pattern_tx #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Drives a load request and queues the bit stream plus predicted detector output.
  task automatic applyStimulus(input logic [15:0] d, input logic [4:0] l,
                               output int n, output logic last);
    int   st;
    logic prev;
    logic b;
    logic m;
    n    = ((l == 5'd0) || (l > 5'd16)) ? 16 : int'(l);
    st   = 0;
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = d[i];
      sb.push_back('{b: b, ex: prev});
      m = 1'b0;
      if (st == 0) st = b ? 1 : 2;
      else if (st == 1) begin
        if (b) begin st = 0; m = 1'b1; end else st = 2;
      end else begin
        if (!b) begin st = 0; m = 1'b1; end else st = 1;
      end
      prev = m;
    end
    last     = prev;
    bus.data = d;
    bus.len  = l;
    bus.load = 1'b1;
  endtask

  task automatic test_reset();
    bus.load = 1'b0;
    bus.data = 16'h0;
    bus.len  = 5'd0;
    #2 reset = 1'b1;
    #1;
    assertions++;
    if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready); end
    assertions++;
    if (bus.bit_valid !== 1'b0 || bus.done !== 1'b0 || bus.expect_out !== 1'b0 || bus.bit_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valid=%b done=%b exp=%b bit=%b expected all 0",
               bus.bit_valid, bus.done, bus.expect_out, bus.bit_out);
    end
    assertions++;
    if (bus.pair_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_pairs: got %0d expected 0", bus.pair_count); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_patterns();
    logic [15:0] pdata[6];
    logic [4:0]  plen[6];
    int          ppairs[6];
    int          n;
    logic        last;
    item_t       it;
    pdata  = '{16'h5772, 16'h0000, 16'hAAAA, 16'h0007, 16'h0001, 16'hFFFF};
    plen   = '{5'd0, 5'd16, 5'd16, 5'd3, 5'd1, 5'd20};
    ppairs = '{3, 8, 0, 1, 0, 8};
    for (int p = 0; p < 6; p++) begin
      assertions++;
      if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL pat%0d_ready_before: got %b expected 1", p, bus.ready); end
      applyStimulus(pdata[p], plen[p], n, last);
      @(posedge clock);
      #1 bus.load = 1'b0;
      for (int c = 1; c <= n; c++) begin
        @(negedge clock);
        assertions++;
        if (bus.bit_valid !== 1'b1 || bus.done !== 1'b0) begin
          failures++;
          $display("[TB] FAIL pat%0d_valid_c%0d: got valid=%b done=%b expected 1/0", p, c, bus.bit_valid, bus.done);
        end
        assertions++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL pat%0d_sb_empty: got empty queue expected item", p);
        end else begin
          it = sb.pop_front();
          if (bus.bit_out !== it.b || bus.expect_out !== it.ex) begin
            failures++;
            $display("[TB] FAIL pat%0d_bit%0d: got bit=%b exp=%b expected bit=%b exp=%b",
                     p, c - 1, bus.bit_out, bus.expect_out, it.b, it.ex);
          end
        end
      end
      @(negedge clock);
      assertions++;
      if (bus.done !== 1'b1 || bus.bit_valid !== 1'b0 || bus.ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL pat%0d_done: got done=%b valid=%b ready=%b expected 1/0/0", p, bus.done, bus.bit_valid, bus.ready);
      end
      assertions++;
      if (bus.expect_out !== last) begin failures++; $display("[TB] FAIL pat%0d_last_expect: got %b expected %b", p, bus.expect_out, last); end
      assertions++;
      if (bus.pair_count !== ppairs[p][3:0]) begin
        failures++;
        $display("[TB] FAIL pat%0d_pairs: got %0d expected %0d", p, bus.pair_count, ppairs[p]);
      end
      @(negedge clock);
      assertions++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.expect_out !== 1'b0 || bus.pair_count !== ppairs[p][3:0]) begin
        failures++;
        $display("[TB] FAIL pat%0d_idle: got ready=%b done=%b exp=%b pairs=%0d expected 1/0/0/%0d",
                 p, bus.ready, bus.done, bus.expect_out, bus.pair_count, ppairs[p]);
      end
    end
  endtask

  task automatic test_reset_midshift();
    int    n;
    logic  last;
    item_t it;
    applyStimulus(16'hFFFF, 5'd16, n, last);
    @(posedge clock);
    #1 bus.load = 1'b0;
    repeat (5) @(negedge clock);
    assertions++;
    if (bus.pair_count !== 4'd2) begin failures++; $display("[TB] FAIL mid_pairs_before: got %0d expected 2", bus.pair_count); end
    #1 reset = 1'b1;
    #1;
    assertions++;
    if (bus.ready !== 1'b1 || bus.bit_valid !== 1'b0 || bus.bit_out !== 1'b0 || bus.done !== 1'b0 || bus.expect_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got ready=%b valid=%b bit=%b done=%b exp=%b expected 1/0/0/0/0",
               bus.ready, bus.bit_valid, bus.bit_out, bus.done, bus.expect_out);
    end
    assertions++;
    if (bus.pair_count !== 4'd0) begin failures++; $display("[TB] FAIL mid_reset_pairs: got %0d expected 0", bus.pair_count); end
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    applyStimulus(16'h0007, 5'd3, n, last);
    @(posedge clock);
    #1 bus.load = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      assertions++;
      if (sb.size() == 0 || bus.bit_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL restart_c%0d: got valid=%b queue=%0d expected valid=1 with item", c, bus.bit_valid, sb.size());
      end else begin
        it = sb.pop_front();
        if (bus.bit_out !== it.b || bus.expect_out !== it.ex) begin
          failures++;
          $display("[TB] FAIL restart_bit%0d: got bit=%b exp=%b expected bit=%b exp=%b",
                   c - 1, bus.bit_out, bus.expect_out, it.b, it.ex);
        end
      end
    end
    @(negedge clock);
    assertions++;
    if (bus.done !== 1'b1 || bus.pair_count !== 4'd1) begin
      failures++;
      $display("[TB] FAIL restart_done: got done=%b pairs=%0d expected 1/1", bus.done, bus.pair_count);
    end
    @(negedge clock);
    assertions++;
    if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL restart_ready: got %b expected 1", bus.ready); end
  endtask

  task automatic test_back_to_back();
    int    n;
    logic  last;
    item_t it;
    for (int k = 0; k < 3; k++) applyStimulus(16'h0003, 5'd2, n, last);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      case ((c - 1) % 4)
        0, 1: begin
          assertions++;
          if (sb.size() == 0 || bus.bit_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_valid_c%0d: got valid=%b queue=%0d expected valid=1 with item", c, bus.bit_valid, sb.size());
          end else begin
            it = sb.pop_front();
            if (bus.bit_out !== it.b || bus.expect_out !== it.ex) begin
              failures++;
              $display("[TB] FAIL b2b_bit_c%0d: got bit=%b exp=%b expected bit=%b exp=%b",
                       c, bus.bit_out, bus.expect_out, it.b, it.ex);
            end
          end
          bus.data = 16'h0000;
          bus.len  = 5'd5;
        end
        2: begin
          assertions++;
          if (bus.done !== 1'b1 || bus.expect_out !== 1'b1 || bus.pair_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL b2b_done_c%0d: got done=%b exp=%b pairs=%0d expected 1/1/1",
                     c, bus.done, bus.expect_out, bus.pair_count);
          end
        end
        default: begin
          assertions++;
          if (bus.ready !== 1'b1 || bus.pair_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL b2b_ready_c%0d: got ready=%b pairs=%0d expected 1/1", c, bus.ready, bus.pair_count);
          end
          bus.data = 16'h0003;
          bus.len  = 5'd2;
          if (c == 12) bus.load = 1'b0;
        end
      endcase
    end
    @(negedge clock);
    assertions++;
    if (bus.ready !== 1'b1 || bus.bit_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL b2b_end: got ready=%b valid=%b queue=%0d expected 1/0/0", bus.ready, bus.bit_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_reset_midshift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/pair_pattern_tx.md
PAIR_PATTERN_TX -- requirements
Module: pair_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the maximum pattern length in bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  start request, sampled only while ready=1.
REQ-005 SHALL have port data  input  WIDTH  pattern to serialize, LSB sent first.
REQ-006 SHALL have port len  input  5  number of bits to send: 1..16, with 0 meaning 16.
REQ-007 SHALL have port ready  output  1  block is idle and accepts load.
REQ-008 SHALL have port bit_valid  output  1  bit_out carries a pattern bit this cycle.
REQ-009 SHALL have port bit_out  output  1  serial bit, fed to the pair-detector input.
REQ-010 SHALL have port expect_out  output  1  predicted registered detector output after the edge that consumed the previous bit.
REQ-011 SHALL have port pair_count  output  4  running count of non-overlapping equal-bit pairs sent.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking the end of a pattern.

Function
REQ-013 SHALL implement control FSM states IDLE, SHIFT and DONE, with ready=1 only in IDLE.
REQ-014 SHALL, at a clock edge in IDLE with load=1, capture data into a shift register, set bit counter to len (0 -> 16), clear pair_count, set model state to START, and enter SHIFT.
REQ-015 SHALL ignore load in SHIFT and DONE, with no effect on the shift register, counter or model.
REQ-016 SHALL drive bit_valid=1 and bit_out=shift register bit 0 combinationally in SHIFT; in IDLE and DONE, bit_valid=0 and bit_out=0.
REQ-017 SHALL, at each edge in SHIFT, shift right by one, decrement the counter and update the model; when the counter is 1 at that edge, the next state SHALL be DONE.
REQ-018 SHALL implement the model states START, ONE and ZERO with these transitions on bit b:
- START: b=1 -> ONE, b=0 -> ZERO; no match.
- ONE: b=1 -> START with match, b=0 -> ZERO.
- ZERO: b=0 -> START with match, b=1 -> ONE.
REQ-019 SHALL register expect_out at each SHIFT edge as the match flag of that bit, and SHALL clear expect_out at every edge outside SHIFT.
REQ-020 SHALL increment pair_count on each match, saturating at 15.
REQ-021 SHALL assert done=1 for exactly the one cycle in DONE and return to IDLE at the next edge.
REQ-022 SHALL hold pair_count through DONE and IDLE until the next accepted load.
REQ-023 SHALL meet this latency for a pattern of N bits:
- bit_valid high on the N cycles following the load edge.
- done on cycle N+1.
- ready on cycle N+2.
REQ-024 SHALL accept load in the first IDLE cycle after DONE, so back-to-back patterns are spaced by one ready cycle.
REQ-025 SHALL treat len values 17..31 as 16.

Reset
REQ-026 SHALL, while reset=1, immediately force the following, regardless of current state including mid-SHIFT:
- FSM=IDLE, model=START, shift register=0, counter=0.
- ready=1, bit_valid=0, bit_out=0, expect_out=0, pair_count=0, done=0.
REQ-027 SHALL accept load at the first rising edge after reset deasserts.

Verification
REQ-028 SHALL cover this case: data=16'b0101_0111_0111_0010, len=0 -> 16 bits 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0; expect_out high after bits 3, 5 and 9; pair_count=3; done on cycle 17.
REQ-029 SHALL cover this case: data=16'h0000, len=16 -> expect_out high after every odd-indexed bit; pair_count=8.
REQ-030 SHALL cover this case: data=16'hAAAA, len=16 -> expect_out never high; pair_count=0.
REQ-031 SHALL cover this case: data=16'h0007, len=3 -> bits 1,1,1; one match after bit 1; pair_count=1; done on cycle 4; ready on cycle 5.
REQ-032 SHALL cover this case: reset asserted after 5 bits of data=16'hFFFF -> same cycle ready=1, bit_valid=0, pair_count=0; a new load 2 cycles after reset deasserts starts cleanly.
REQ-033 SHALL cover this case: load held high continuously with data=16'h0003, len=2 -> patterns at period 4 cycles; pair_count=1 each; load ignored during SHIFT and DONE.
